// File: rtl/spi_arbiter_if.sv
// Client request/grant bus plus SPI pins shared between spi_arbiter and its users.
// The master modport is the arbiter side; the slave modport is the client/board side.
interface spi_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] tx_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rx_data;
    logic                      busy;
    logic [NUM_REQ-1:0]        spi_cs_l;
    logic                      spi_clk;
    logic                      spi_mosi;
    logic                      spi_miso;

    modport master (
        input  req, tx_data, spi_miso,
        output gnt, done, rx_data, busy, spi_cs_l, spi_clk, spi_mosi
    );

    modport slave (
        output req, tx_data, spi_miso,
        input  gnt, done, rx_data, busy, spi_cs_l, spi_clk, spi_mosi
    );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one mode-0 full-duplex SPI master between NUM_REQ clients.
// Each grant runs one DATA_W-bit transfer MSB-first and returns the reply with a done pulse.
module spi_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          reset,
    spi_arbiter_if.master bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    sel_q, sel_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  cs_l_q, cs_l_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                busy_q, busy_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;

    logic                win_found_c;
    logic [PTR_W-1:0]    win_idx_c;
    logic [31:0]         cand_c;
    logic [DATA_W-1:0]   tx_word_c;
    logic                div_last_c;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand_c = 32'(ptr_q) + 32'(i);
            if (cand_c >= NUM_REQ) cand_c = cand_c - NUM_REQ;
            if (!win_found_c && bus.req[PTR_W'(cand_c)]) begin
                win_found_c = 1'b1;
                win_idx_c   = PTR_W'(cand_c);
            end
        end
    end

    always_comb begin
        tx_word_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_idx_c == PTR_W'(i)) tx_word_c = bus.tx_data[i*DATA_W +: DATA_W];
        end
    end

    assign div_last_c = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        cs_l_d    = cs_l_q;
        rx_data_d = rx_data_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_d     = bit_q;
        div_d     = div_q;
        busy_d    = busy_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;

        case (state_q)
            S_IDLE: begin
                if (win_found_c) begin
                    state_d = S_SETUP;
                    sel_d   = win_idx_c;
                    gnt_d   = NUM_REQ'(1) << win_idx_c;
                    cs_l_d  = ~(NUM_REQ'(1) << win_idx_c);
                    busy_d  = 1'b1;
                    tx_sr_d = tx_word_c;
                    mosi_d  = tx_word_c[DATA_W-1];
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            S_SETUP: begin
                if (div_last_c) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.spi_miso};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            // Rising spi_clk samples miso; falling spi_clk advances mosi.
            S_SHIFT: begin
                if (!div_last_c) begin
                    div_d = div_q + DIV_W'(1);
                end else if (sclk_q) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    tx_sr_d = tx_sr_q << 1;
                    mosi_d  = tx_sr_q[DATA_W-2];
                end else if (bit_q == BIT_W'(DATA_W - 1)) begin
                    div_d   = '0;
                    state_d = S_HOLD;
                    mosi_d  = 1'b0;
                end else begin
                    div_d   = '0;
                    bit_d   = bit_q + BIT_W'(1);
                    sclk_d  = 1'b1;
                    rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.spi_miso};
                end
            end
            S_HOLD: begin
                if (div_last_c) begin
                    state_d   = S_DONE;
                    div_d     = '0;
                    cs_l_d    = '1;
                    gnt_d     = '0;
                    done_d    = gnt_q;
                    rx_data_d = rx_sr_q;
                    ptr_d     = (sel_q == PTR_W'(NUM_REQ - 1)) ? '0 : sel_q + PTR_W'(1);
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            cs_l_q    <= '1;
            rx_data_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            cs_l_q    <= cs_l_d;
            rx_data_q <= rx_data_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.busy     = busy_q;
    assign bus.spi_cs_l = cs_l_q;
    assign bus.spi_clk  = sclk_q;
    assign bus.spi_mosi = mosi_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: a CLK_DIV=2 instance for arbitration scenarios and a
// CLK_DIV=1 instance for the fast-clock build, each with a mode-0 SPI slave model.
module tb_spi_arbiter;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;

    spi_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) a_if ();
    spi_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) b_if ();

    spi_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(2)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
    spi_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

    // Slave A: presents its MSB at cs fall, captures mosi on rising spi_clk, shifts on falling.
    logic [15:0] a_slave_word = '0, a_sh = '0, a_cap = '0;
    int a_rises = 0;
    logic a_sel, a_sel_prev = 1'b0, a_clk_prev = 1'b0;
    assign a_sel = ~&a_if.spi_cs_l;
    assign a_if.spi_miso = a_sh[15];
    always @(a_sel or a_if.spi_clk) begin
        if (a_sel && !a_sel_prev) begin
            a_sh = a_slave_word; a_cap = '0; a_rises = 0;
        end else if (a_if.spi_clk && !a_clk_prev) begin
            a_cap = {a_cap[14:0], a_if.spi_mosi}; a_rises++;
        end else if (!a_if.spi_clk && a_clk_prev && a_sel) begin
            a_sh = {a_sh[14:0], 1'b0};
        end
        a_sel_prev = a_sel;
        a_clk_prev = a_if.spi_clk;
    end

    logic [15:0] b_slave_word = '0, b_sh = '0, b_cap = '0;
    int b_rises = 0;
    time b_last_rise = 0, b_period = 0;
    logic b_sel, b_sel_prev = 1'b0, b_clk_prev = 1'b0;
    assign b_sel = ~&b_if.spi_cs_l;
    assign b_if.spi_miso = b_sh[15];
    always @(b_sel or b_if.spi_clk) begin
        if (b_sel && !b_sel_prev) begin
            b_sh = b_slave_word; b_cap = '0; b_rises = 0;
        end else if (b_if.spi_clk && !b_clk_prev) begin
            b_cap = {b_cap[14:0], b_if.spi_mosi};
            if (b_rises > 0) b_period = $time - b_last_rise;
            b_last_rise = $time;
            b_rises++;
        end else if (!b_if.spi_clk && b_clk_prev && b_sel) begin
            b_sh = {b_sh[14:0], 1'b0};
        end
        b_sel_prev = b_sel;
        b_clk_prev = b_if.spi_clk;
    end

    bit sel_b = 1'b0;
    logic [NR-1:0] m_gnt, m_done, m_cs;
    logic [DW-1:0] m_rx;
    assign m_gnt  = sel_b ? b_if.gnt      : a_if.gnt;
    assign m_done = sel_b ? b_if.done     : a_if.done;
    assign m_cs   = sel_b ? b_if.spi_cs_l : a_if.spi_cs_l;
    assign m_rx   = sel_b ? b_if.rx_data  : a_if.rx_data;

    // Observes one transfer from grant to done (or abort). act_kind 1: drop req and
    // corrupt tx of the granted requester; 2: assert reset. Returns at the done negedge.
    task automatic measure(input int act_at, input int act_kind, output int g, output int cs_low,
                           output int lat, output int d_idx, output logic [15:0] rx,
                           output int gcyc, output bit bad);
        int k;
        g = -1; cs_low = 0; lat = 0; d_idx = -1; rx = '0; gcyc = 0; bad = 1'b0;
        k = 0;
        while (m_gnt == '0 && k < 400) begin @(negedge clk); k++; end
        if (m_gnt == '0) begin bad = 1'b1; return; end
        for (int i = 0; i < int'(NR); i++) if (m_gnt[i]) g = i;
        gcyc = cyc;
        for (int n = 1; n <= 400; n++) begin
            if ($countones(m_gnt) > 1) bad = 1'b1;
            if (m_done != '0) begin
                for (int i = 0; i < int'(NR); i++) if (m_done[i]) d_idx = i;
                rx = m_rx;
                lat = cyc - gcyc + 1;
                break;
            end
            if (m_cs[g] == 1'b0) cs_low++;
            for (int i = 0; i < int'(NR); i++) if (i != g && m_cs[i] == 1'b0) bad = 1'b1;
            if (m_gnt == '0) break;
            if (n == act_at && act_kind == 1) begin
                a_if.req[g] = 1'b0;
                a_if.tx_data[g*DW +: DW] = 16'hFFFF;
            end
            if (n == act_at && act_kind == 2) reset = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a_if.req = '0;
        b_if.req = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (a_if.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", a_if.gnt); else n_pass++;
        n_checks++; if (a_if.done !== 4'b0000) $display("FAIL reset_done: got %b want 0000", a_if.done); else n_pass++;
        n_checks++; if (a_if.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", a_if.busy); else n_pass++;
        n_checks++; if (a_if.rx_data !== 16'h0000) $display("FAIL reset_rx: got %h want 0000", a_if.rx_data); else n_pass++;
        n_checks++; if (a_if.spi_cs_l !== 4'b1111) $display("FAIL reset_cs: got %b want 1111", a_if.spi_cs_l); else n_pass++;
        n_checks++; if (a_if.spi_clk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", a_if.spi_clk); else n_pass++;
        n_checks++; if (a_if.spi_mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", a_if.spi_mosi); else n_pass++;
        n_checks++; if (b_if.spi_cs_l !== 4'b1111) $display("FAIL reset_cs_b: got %b want 1111", b_if.spi_cs_l); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int g, csl, lat, d, gc; logic [15:0] rx; bit bad;
        sel_b = 1'b0;
        a_slave_word = 16'h3425;
        a_if.tx_data[15:0] = 16'hA569;
        a_if.req = 4'b0001;
        measure(0, 0, g, csl, lat, d, rx, gc, bad);
        a_if.req = 4'b0000;
        n_checks++; if (g !== 0) $display("FAIL single_gnt: got %0d want 0", g); else n_pass++;
        n_checks++; if (d !== 0) $display("FAIL single_done: got %0d want 0", d); else n_pass++;
        n_checks++; if (rx !== 16'h3425) $display("FAIL single_rx: got %h want 3425", rx); else n_pass++;
        n_checks++; if (a_cap !== 16'hA569) $display("FAIL single_slave_cap: got %h want a569", a_cap); else n_pass++;
        n_checks++; if (a_rises !== 16) $display("FAIL single_rises: got %0d want 16", a_rises); else n_pass++;
        n_checks++; if (csl !== 68) $display("FAIL single_cs_low: got %0d want 68", csl); else n_pass++;
        n_checks++; if (lat !== 69) $display("FAIL single_latency: got %0d want 69", lat); else n_pass++;
        n_checks++; if (bad !== 1'b0) $display("FAIL single_cs_onehot: got %b want 0", bad); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (a_if.busy !== 1'b0 || a_if.gnt !== 4'b0) $display("FAIL single_idle: got busy=%b gnt=%b want 0/0000", a_if.busy, a_if.gnt); else n_pass++;
        n_checks++; if (a_if.rx_data !== 16'h3425) $display("FAIL single_rx_hold: got %h want 3425", a_if.rx_data); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int g0, g1, csl, lat, d0, d1, gc0, gc1; logic [15:0] rx; bit bad0, bad1;
        logic [15:0] cap0;
        do_reset();
        a_slave_word = 16'hC3C3;
        a_if.tx_data[15:0]  = 16'h0001;
        a_if.tx_data[47:32] = 16'h2563;
        a_if.req = 4'b0101;
        measure(0, 0, g0, csl, lat, d0, rx, gc0, bad0);
        cap0 = a_cap;
        a_if.req[0] = 1'b0;
        n_checks++; if (g0 !== 0 || d0 !== 0) $display("FAIL simul_first: got gnt=%0d done=%0d want 0/0", g0, d0); else n_pass++;
        n_checks++; if (cap0 !== 16'h0001) $display("FAIL simul_cap0: got %h want 0001", cap0); else n_pass++;
        n_checks++; if (rx !== 16'hC3C3) $display("FAIL simul_rx0: got %h want c3c3", rx); else n_pass++;
        measure(0, 0, g1, csl, lat, d1, rx, gc1, bad1);
        a_if.req = 4'b0000;
        n_checks++; if (g1 !== 2 || d1 !== 2) $display("FAIL simul_second: got gnt=%0d done=%0d want 2/2", g1, d1); else n_pass++;
        n_checks++; if (gc1 - gc0 !== 70) $display("FAIL simul_gap: got %0d want 70", gc1 - gc0); else n_pass++;
        n_checks++; if (a_cap !== 16'h2563) $display("FAIL simul_cap2: got %h want 2563", a_cap); else n_pass++;
        n_checks++; if (bad0 || bad1) $display("FAIL simul_onehot: got %b%b want 00", bad0, bad1); else n_pass++;
    endtask

    task automatic test_fairness();
        int g, csl, lat, d, gc, prev_gc; logic [15:0] rx; bit bad;
        do_reset();
        a_if.tx_data = 64'h4444_3333_2222_1111;
        a_if.req = 4'b1111;
        prev_gc = 0;
        for (int i = 0; i < 8; i++) begin
            measure(0, 0, g, csl, lat, d, rx, gc, bad);
            n_checks++; if (g !== i % 4 || d !== i % 4) $display("FAIL fair_order_%0d: got gnt=%0d done=%0d want %0d", i, g, d, i % 4); else n_pass++;
            if (i > 0) begin
                n_checks++; if (gc - prev_gc !== 70) $display("FAIL fair_period_%0d: got %0d want 70", i, gc - prev_gc); else n_pass++;
            end
            n_checks++; if (bad !== 1'b0) $display("FAIL fair_onehot_%0d: got %b want 0", i, bad); else n_pass++;
            prev_gc = gc;
        end
        a_if.req = 4'b0000;
    endtask

    task automatic test_req_drop();
        int g, csl, lat, d, gc; logic [15:0] rx; bit bad;
        a_slave_word = 16'h5A5A;
        a_if.tx_data[31:16] = 16'h9B63;
        a_if.req = 4'b0010;
        measure(10, 1, g, csl, lat, d, rx, gc, bad);
        n_checks++; if (g !== 1 || d !== 1) $display("FAIL drop_done: got gnt=%0d done=%0d want 1/1", g, d); else n_pass++;
        n_checks++; if (a_cap !== 16'h9B63) $display("FAIL drop_word: got %h want 9b63", a_cap); else n_pass++;
        n_checks++; if (rx !== 16'h5A5A) $display("FAIL drop_rx: got %h want 5a5a", rx); else n_pass++;
        n_checks++; if (csl !== 68) $display("FAIL drop_cs_low: got %0d want 68", csl); else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++; if (a_if.gnt !== 4'b0 || a_if.busy !== 1'b0) $display("FAIL drop_no_regrant: got gnt=%b busy=%b want 0000/0", a_if.gnt, a_if.busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int g, csl, lat, d, gc; logic [15:0] rx; bit bad;
        a_if.tx_data[47:32] = 16'hFFFF;
        a_if.req = 4'b0100;
        measure(32, 2, g, csl, lat, d, rx, gc, bad);
        n_checks++; if (g !== 2) $display("FAIL rmid_gnt: got %0d want 2", g); else n_pass++;
        n_checks++; if (a_rises !== 8) $display("FAIL rmid_bit: got %0d rises want 8", a_rises); else n_pass++;
        n_checks++; if (d !== -1 || a_if.done !== 4'b0) $display("FAIL rmid_no_done: got %0d/%b want -1/0000", d, a_if.done); else n_pass++;
        n_checks++; if (a_if.spi_cs_l !== 4'b1111) $display("FAIL rmid_cs: got %b want 1111", a_if.spi_cs_l); else n_pass++;
        n_checks++; if (a_if.spi_clk !== 1'b0 || a_if.busy !== 1'b0) $display("FAIL rmid_sclk_busy: got %b/%b want 0/0", a_if.spi_clk, a_if.busy); else n_pass++;
        n_checks++; if (a_if.rx_data !== 16'h0000) $display("FAIL rmid_rx: got %h want 0000", a_if.rx_data); else n_pass++;
        a_if.req = 4'b1010;
        reset = 1'b0;
        measure(0, 0, g, csl, lat, d, rx, gc, bad);
        a_if.req = 4'b0000;
        n_checks++; if (g !== 1 || d !== 1) $display("FAIL rmid_ptr0: got gnt=%0d done=%0d want 1/1", g, d); else n_pass++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_clkdiv1();
        int g, csl, lat, d, gc; logic [15:0] rx; bit bad;
        sel_b = 1'b1;
        b_slave_word = 16'h9B22;
        b_if.tx_data[15:0] = 16'h6A61;
        b_if.req = 4'b0001;
        measure(0, 0, g, csl, lat, d, rx, gc, bad);
        b_if.req = 4'b0000;
        n_checks++; if (g !== 0 || d !== 0) $display("FAIL div1_done: got gnt=%0d done=%0d want 0/0", g, d); else n_pass++;
        n_checks++; if (rx !== 16'h9B22) $display("FAIL div1_rx: got %h want 9b22", rx); else n_pass++;
        n_checks++; if (b_cap !== 16'h6A61) $display("FAIL div1_slave_cap: got %h want 6a61", b_cap); else n_pass++;
        n_checks++; if (csl !== 34) $display("FAIL div1_cs_low: got %0d want 34", csl); else n_pass++;
        n_checks++; if (lat !== 35) $display("FAIL div1_latency: got %0d want 35", lat); else n_pass++;
        n_checks++; if (b_rises !== 16) $display("FAIL div1_rises: got %0d want 16", b_rises); else n_pass++;
        n_checks++; if (b_period !== 20) $display("FAIL div1_sclk_period: got %0t want 20", b_period); else n_pass++;
        n_checks++; if (bad !== 1'b0) $display("FAIL div1_onehot: got %b want 0", bad); else n_pass++;
        sel_b = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        a_if.req = '0; a_if.tx_data = '0;
        b_if.req = '0; b_if.tx_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_req_drop();
        test_reset_mid();
        test_clkdiv1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
